// File: rtl/legv8_control_unit.sv
// LEGv8 multicycle control unit: two-cycle FETCH/EXECUTE sequencer that
// decodes a LEGv8 subset into a datapath control word and an immediate,
// owns the PC, and parks in HALT on any unsupported opcode.
module legv8_control_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] instruction,
  input  logic [3:0]  status,
  output logic [31:0] ControlWord,
  output logic [63:0] constant,
  output logic [31:0] pc,
  output logic        halted
);

  typedef enum logic [1:0] {S_FETCH = 2'd0, S_EXECUTE = 2'd1, S_HALT = 2'd2} state_t;
  typedef enum logic [2:0] {K_RTYPE, K_ITYPE, K_LDUR, K_STUR, K_B, K_CBZ, K_BAD} kind_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_ir;

  kind_t       w_kind;
  logic [4:0]  w_fs;
  logic        w_c0;
  logic [31:0] w_b_off;
  logic [31:0] w_cbz_off;
  logic [63:0] w_imm12;
  logic [63:0] w_dt_sext;
  logic        w_unused_flags;

  // Only Z takes part in control decisions; V, C and N are ignored.
  assign w_unused_flags = ^status[3:1];

  assign w_b_off   = {{4{r_ir[25]}}, r_ir[25:0], 2'b00};
  assign w_cbz_off = {{11{r_ir[23]}}, r_ir[23:5], 2'b00};
  assign w_imm12   = {52'd0, r_ir[21:10]};
  assign w_dt_sext = {{55{r_ir[20]}}, r_ir[20:12]};
  assign pc        = r_pc;

  // State register: asynchronous reset restarts at a FETCH of address 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_state_next;
    end
  end

  // PC and instruction register; IR loads during FETCH, PC moves at the end of EXECUTE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc <= 32'd0;
      r_ir <= 32'd0;
    end else begin
      r_pc <= w_pc_next;
      if (r_state == S_FETCH) begin
        r_ir <= instruction;
      end
    end
  end

  // Opcode decode, longest opcode first (11, 10, 8, then 6 bits).
  always_comb begin
    w_kind = K_BAD;
    w_fs   = 5'b00000;
    w_c0   = 1'b0;
    case (r_ir[31:21])
      11'b10001011000: begin w_kind = K_RTYPE; w_fs = 5'b01000; end
      11'b11001011000: begin w_kind = K_RTYPE; w_fs = 5'b01001; w_c0 = 1'b1; end
      11'b10001010000: begin w_kind = K_RTYPE; w_fs = 5'b00000; end
      11'b10101010000: begin w_kind = K_RTYPE; w_fs = 5'b00100; end
      11'b11001010000: begin w_kind = K_RTYPE; w_fs = 5'b01100; end
      11'b11111000010: begin w_kind = K_LDUR;  w_fs = 5'b01000; end
      11'b11111000000: begin w_kind = K_STUR;  w_fs = 5'b01000; end
      default: begin
        case (r_ir[31:22])
          10'b1001000100: begin w_kind = K_ITYPE; w_fs = 5'b01000; end
          10'b1101000100: begin w_kind = K_ITYPE; w_fs = 5'b01001; w_c0 = 1'b1; end
          10'b1001001000: begin w_kind = K_ITYPE; w_fs = 5'b00000; end
          10'b1011001000: begin w_kind = K_ITYPE; w_fs = 5'b00100; end
          default: begin
            if (r_ir[31:24] == 8'b10110100) begin
              w_kind = K_CBZ;
              w_fs   = 5'b00100;
            end else if (r_ir[31:26] == 6'b000101) begin
              w_kind = K_B;
            end
          end
        endcase
      end
    endcase
  end

  // Next state and next PC; CBZ samples Z during its own EXECUTE cycle.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    case (r_state)
      S_FETCH: w_state_next = S_EXECUTE;
      S_EXECUTE: begin
        w_state_next = S_FETCH;
        case (w_kind)
          K_BAD: w_state_next = S_HALT;
          K_B:   w_pc_next = r_pc + w_b_off;
          K_CBZ: w_pc_next = status[0] ? (r_pc + w_cbz_off) : (r_pc + 32'd4);
          default: w_pc_next = r_pc + 32'd4;
        endcase
      end
      default: w_state_next = S_HALT;
    endcase
  end

  // Outputs: decoded word only during EXECUTE, forced to zero while reset is low.
  always_comb begin
    ControlWord = 32'd0;
    constant    = 64'd0;
    halted      = (r_state == S_HALT);
    if (reset && (r_state == S_EXECUTE)) begin
      case (w_kind)
        K_RTYPE, K_ITYPE: begin
          ControlWord[4:0]   = r_ir[4:0];
          ControlWord[9:5]   = r_ir[9:5];
          ControlWord[14:10] = r_ir[20:16];
          ControlWord[15]    = 1'b1;
          ControlWord[16]    = (w_kind == K_ITYPE);
          ControlWord[21:17] = w_fs;
          ControlWord[22]    = w_c0;
          ControlWord[24]    = 1'b1;
          if (w_kind == K_ITYPE) begin
            constant = w_imm12;
          end
        end
        K_LDUR: begin
          ControlWord[4:0]   = r_ir[4:0];
          ControlWord[9:5]   = r_ir[9:5];
          ControlWord[15]    = 1'b1;
          ControlWord[16]    = 1'b1;
          ControlWord[21:17] = w_fs;
          ControlWord[23]    = 1'b1;
          ControlWord[26]    = 1'b1;
          ControlWord[28:27] = 2'b11;
          ControlWord[30]    = 1'b1;
          constant           = w_dt_sext;
        end
        K_STUR: begin
          ControlWord[9:5]   = r_ir[9:5];
          ControlWord[14:10] = r_ir[4:0];
          ControlWord[16]    = 1'b1;
          ControlWord[21:17] = w_fs;
          ControlWord[23]    = 1'b1;
          ControlWord[25]    = 1'b1;
          ControlWord[26]    = 1'b1;
          ControlWord[28:27] = 2'b11;
          ControlWord[29]    = 1'b1;
          constant           = w_dt_sext;
        end
        K_CBZ: begin
          ControlWord[9:5]   = r_ir[4:0];
          ControlWord[16]    = 1'b1;
          ControlWord[21:17] = w_fs;
        end
        default: ControlWord = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_legv8_control_unit.sv
// Directed bench for legv8_control_unit: a small instruction memory indexed
// by pc, hand-encoded programs, and hand-computed control words.
module tb_legv8_control_unit;

  logic        clk;
  logic        reset;
  logic [31:0] instruction;
  logic [3:0]  status;
  logic [31:0] ControlWord;
  logic [63:0] constant;
  logic [31:0] pc;
  logic        halted;

  logic [31:0] imem [0:63];

  int total  = 0;
  int passed = 0;
  int failed = 0;

  // Hand-encoded instructions
  localparam logic [31:0] I_ADDI = 32'h910063E0; // ADDI X0, XZR, #24
  localparam logic [31:0] I_ADD  = 32'h8B020023; // ADD  X3, X1, X2
  localparam logic [31:0] I_SUB  = 32'hCB0003E1; // SUB  X1, XZR, X0
  localparam logic [31:0] I_STUR = 32'hF80003E1; // STUR X1, [XZR, #0]
  localparam logic [31:0] I_LDUR = 32'hF85F83E2; // LDUR X2, [XZR, #-8]
  localparam logic [31:0] I_CBZ  = 32'hB4000065; // CBZ  X5, #3
  localparam logic [31:0] I_BM3  = 32'h17FFFFFD; // B    #-3
  localparam logic [31:0] I_BM2  = 32'h17FFFFFE; // B    #-2
  localparam logic [31:0] I_BP1  = 32'h14000001; // B    #1
  localparam logic [31:0] I_BP3  = 32'h14000003; // B    #3

  // Hand-computed control words
  localparam logic [31:0] CW_ADDI = 32'h011183E0;
  localparam logic [31:0] CW_ADD  = 32'h01108823;
  localparam logic [31:0] CW_SUB  = 32'h015283E1;
  localparam logic [31:0] CW_STUR = 32'h3E9107E0;
  localparam logic [31:0] CW_LDUR = 32'h5C9183E2;
  localparam logic [31:0] CW_CBZ  = 32'h000900A0;

  legv8_control_unit dut (
    .clock       (clk),
    .reset       (reset),
    .instruction (instruction),
    .status      (status),
    .ControlWord (ControlWord),
    .constant    (constant),
    .pc          (pc),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instruction = imem[pc[7:2]];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
  endtask

  // Entered at a negedge during FETCH; leaves at the negedge of the next FETCH.
  task automatic run_instr(input string tag, input logic [31:0] at_pc, input logic [31:0] exp_cw,
                           input logic [63:0] exp_k, input logic [31:0] next_pc);
    check({tag, "_fetch_pc"}, {32'd0, pc}, {32'd0, at_pc});
    check({tag, "_fetch_cw"}, {32'd0, ControlWord}, 64'd0);
    check({tag, "_fetch_k"}, constant, 64'd0);
    @(posedge clk); @(negedge clk);
    check({tag, "_exec_cw"}, {32'd0, ControlWord}, {32'd0, exp_cw});
    check({tag, "_exec_k"}, constant, exp_k);
    check({tag, "_exec_pc"}, {32'd0, pc}, {32'd0, at_pc});
    check({tag, "_exec_halted"}, {63'd0, halted}, 64'd0);
    @(posedge clk); @(negedge clk);
    check({tag, "_next_pc"}, {32'd0, pc}, {32'd0, next_pc});
    $display("txn %s: pc 0x%08h cw 0x%08h -> pc 0x%08h", tag, at_pc, exp_cw, pc);
  endtask

  initial begin
    reset  = 1'b0;
    status = 4'b0000;
    clear_mem();
    imem[0] = I_ADDI;
    imem[1] = I_ADD;
    #1;
    check("rst_pc", {32'd0, pc}, 64'd0);
    check("rst_cw", {32'd0, ControlWord}, 64'd0);
    check("rst_k", constant, 64'd0);
    check("rst_halted", {63'd0, halted}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Reset asserted in the middle of an ADD's EXECUTE
    run_instr("addi_pre", 32'h0, CW_ADDI, 64'd24, 32'h4);
    @(posedge clk); @(negedge clk);
    check("add_exec_cw", {32'd0, ControlWord}, {32'd0, CW_ADD});
    check("add_exec_pc", {32'd0, pc}, 64'h4);
    #2 reset = 1'b0;
    #1;
    check("async_rst_cw", {32'd0, ControlWord}, 64'd0);
    check("async_rst_pc", {32'd0, pc}, 64'd0);
    check("async_rst_k", constant, 64'd0);
    @(posedge clk); @(negedge clk);
    check("held_rst_cw", {32'd0, ControlWord}, 64'd0);
    check("held_rst_pc", {32'd0, pc}, 64'd0);
    reset = 1'b1;
    run_instr("addi_post_rst", 32'h0, CW_ADDI, 64'd24, 32'h4);

    // Main program: ALU, memory, CBZ taken, backward B, CBZ not taken
    reset = 1'b0;
    clear_mem();
    imem[0] = I_ADDI;
    imem[1] = I_SUB;
    imem[2] = I_STUR;
    imem[3] = I_LDUR;
    imem[4] = I_CBZ;
    imem[7] = I_BM3;
    @(negedge clk);
    reset = 1'b1;
    run_instr("addi", 32'h0, CW_ADDI, 64'd24, 32'h4);
    run_instr("sub", 32'h4, CW_SUB, 64'd0, 32'h8);
    run_instr("stur", 32'h8, CW_STUR, 64'd0, 32'hC);
    run_instr("ldur", 32'hC, CW_LDUR, 64'hFFFF_FFFF_FFFF_FFF8, 32'h10);
    status = 4'b0001;
    run_instr("cbz_taken", 32'h10, CW_CBZ, 64'd0, 32'h1C);
    status = 4'b0000;
    run_instr("b_back", 32'h1C, 32'd0, 64'd0, 32'h10);
    run_instr("cbz_not_taken", 32'h10, CW_CBZ, 64'd0, 32'h14);

    // Branch wrap through 0xFFFFFFFC, then an unsupported opcode at pc 8
    reset = 1'b0;
    clear_mem();
    imem[0]  = I_BP1;
    imem[1]  = I_BM2;
    imem[63] = I_BP3;
    imem[2]  = 32'h00000000;
    @(negedge clk);
    reset = 1'b1;
    run_instr("b_fwd", 32'h0, 32'd0, 64'd0, 32'h4);
    run_instr("b_wrap_back", 32'h4, 32'd0, 64'd0, 32'hFFFF_FFFC);
    run_instr("b_wrap_fwd", 32'hFFFF_FFFC, 32'd0, 64'd0, 32'h8);
    run_instr("bad_opcode", 32'h8, 32'd0, 64'd0, 32'h8);
    for (int i = 0; i < 5; i++) begin
      check("halt_flag", {63'd0, halted}, 64'd1);
      check("halt_pc", {32'd0, pc}, 64'h8);
      check("halt_cw", {32'd0, ControlWord}, 64'd0);
      @(posedge clk); @(negedge clk);
    end
    $display("txn halt: pc 0x%08h halted %0b", pc, halted);
    reset = 1'b0;
    #1;
    check("halt_rst_flag", {63'd0, halted}, 64'd0);
    check("halt_rst_pc", {32'd0, pc}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    run_instr("after_halt", 32'h0, 32'd0, 64'd0, 32'h4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
